roulette_round_ctrl: RTL
========================

Name: roulette_round_ctrl

Overview:
Round sequencer and bank controller for the roulette game. It debounces and edge-detects the player's start key, and latches the player's guess and game mode at the key press. It times a "spin" window, then samples the free-running random number at the end of that window. It then judges win or lose for either game variant (parity guess or exact-number guess), updates the player balance and declares game won or lost. The controller sits between the board keys/switches, the LFSR random source and the HEX/LED display drivers.

Parameters:
START_BAL, 10, balance loaded on reset and on new game
WIN_LIMIT, 20, balance at or above which the game is won
PAY_PARITY, 2, credit for a correct parity guess
PAY_EXACT, 8, credit for a correct exact-number guess
LOSS_AMT, 1, debit for any wrong guess
SPIN_CYCLES, 16, clock cycles the spin window lasts (minimum 2)

Ports:
Clock  input  1  system clock, all state on its rising edge
reset_n  input  1  asynchronous active-low reset
start_key  input  1  raw active-low start key (KEY), asynchronous to Clock
new_game  input  1  synchronous active-high pulse; restarts the game from WIN/LOSE
mode_sel  input  1  0 = parity game, 1 = exact-number game
guess_even  input  1  parity guess: 1 = even, 0 = odd
guess_num  input  5  exact-number guess, 0..31
randnum  input  5  free-running random value from the LFSR
balance  output  6  current player balance, unsigned
spin_num  output  5  number sampled for the last round
busy  output  1  high from key press until the round is judged
win_pulse  output  1  one-cycle pulse when a round is won
lose_pulse  output  1  one-cycle pulse when a round is lost
game_won  output  1  high while in the WIN state
game_lost  output  1  high while in the LOSE state

Behaviour:
- Reset (asynchronous, reset_n low):
  - state = WAIT; balance = START_BAL; spin_num = 0.
  - All pulse and status outputs = 0; synchroniser flops = 1 (key released).
- start_key handling:
  - Two-flop synchroniser, then falling-edge detect produces press, a one-cycle internal strobe, 3 cycles after the edge.
  - A press outside WAIT is ignored and is not queued.
- On a press in WAIT, mode_sel, guess_even and guess_num are latched.
- FSM states: WAIT, SPIN, JUDGE, UPDATE, WIN, LOSE.
  - WAIT: busy = 0. On press, latch the guess, clear the spin counter and go to SPIN.
  - SPIN: busy = 1. The counter increments each cycle. When it reaches SPIN_CYCLES-1, spin_num <= randnum and the FSM goes to JUDGE. SPIN therefore lasts exactly SPIN_CYCLES cycles.
  - JUDGE: one cycle, computes hit.
    - Parity mode: hit = (spin_num != 0) and (spin_num[0] == ~guess_even). Zero loses both parity bets.
    - Exact mode: hit = (spin_num == guess_num).
  - UPDATE: one cycle, busy = 0.
    - On hit: balance <= min(balance + payout, 63), win_pulse = 1.
    - On miss: balance <= balance - LOSS_AMT, clamped at 0; lose_pulse = 1.
    - Then go to WIN if the new balance >= WIN_LIMIT, LOSE if the new balance == 0, else WAIT.
    - The decision uses the new balance, not the old one.
  - WIN / LOSE: game_won or game_lost held high; presses are ignored.
    - new_game: balance <= START_BAL, status outputs clear, state goes to WAIT.
- new_game in WAIT/SPIN/JUDGE/UPDATE also restarts: balance <= START_BAL, state goes to WAIT, the round is aborted and no pulse is emitted.
- Latency: from press to win/lose pulse is SPIN_CYCLES + 2 cycles.
- reset_n asserted mid-round aborts immediately to the reset values.
- The balance is never out of range: arithmetic is done 7 bits wide, then saturated into 6 bits.

Test Plan:
1. Reset, then release → balance = 10, state WAIT, all pulses 0, busy 0.
2. Parity mode, guess_even = 1, randnum held at 6, one key press → busy high for 17 cycles. win_pulse fires at press strobe + 18 cycles; balance 12; spin_num = 6.
3. Parity mode, guess_even = 0, randnum = 0 → lose_pulse, balance 9 (zero loses both parity bets).
4. Exact mode, guess_num = 13, randnum = 13, balance 12 → balance 20, win_pulse, then game_won = 1. A further key press is ignored; new_game → balance 10, WAIT.
5. Ten consecutive losing rounds from 10 → balance reaches 0 and game_lost = 1 after the tenth lose_pulse. A key press during SPIN does not start an extra round.
6. Assert reset_n mid-SPIN with balance 14 → balance 10, WAIT, no pulse. Assert new_game in SPIN → same result synchronously.

Source files
------------

// File: rtl/roulette_round_ctrl.sv
// Round sequencer and bank controller for the roulette game: start-key sync/edge detect,
// spin timing, win/lose judging for parity and exact-number bets, and balance bookkeeping.
module roulette_round_ctrl #(
  parameter int unsigned START_BAL   = 10,
  parameter int unsigned WIN_LIMIT   = 20,
  parameter int unsigned PAY_PARITY  = 2,
  parameter int unsigned PAY_EXACT   = 8,
  parameter int unsigned LOSS_AMT    = 1,
  parameter int unsigned SPIN_CYCLES = 16
) (
  input  logic       Clock,
  input  logic       reset_n,
  input  logic       start_key,
  input  logic       new_game,
  input  logic       mode_sel,
  input  logic       guess_even,
  input  logic [4:0] guess_num,
  input  logic [4:0] randnum,
  output logic [5:0] balance,
  output logic [4:0] spin_num,
  output logic       busy,
  output logic       win_pulse,
  output logic       lose_pulse,
  output logic       game_won,
  output logic       game_lost,
  output logic [2:0] dbg_state
);

  localparam int CW = (SPIN_CYCLES > 2) ? $clog2(SPIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    WAIT   = 3'd0,
    SPIN   = 3'd1,
    JUDGE  = 3'd2,
    UPDATE = 3'd3,
    WIN    = 3'd4,
    LOSE   = 3'd5
  } state_t;

  state_t        state;
  logic          key_s1, key_s2, key_s3;
  logic          press;
  logic          lat_mode, lat_even;
  logic [4:0]    lat_num;
  logic [CW-1:0] spin_cnt;
  logic          hit, hit_now;
  logic [6:0]    sum7, diff7;
  logic [5:0]    new_bal;

  assign dbg_state = state;

  // Zero is neither odd nor even for the bank: both parity bets lose on it.
  always_comb begin
    hit_now = 1'b0;
    if (lat_mode) hit_now = (spin_num == lat_num);
    else          hit_now = (spin_num != 5'd0) && (spin_num[0] == ~lat_even);
  end

  // Arithmetic is 7 bits wide, then saturated back into the 6-bit balance.
  always_comb begin
    sum7    = {1'b0, balance} + (lat_mode ? 7'(PAY_EXACT) : 7'(PAY_PARITY));
    diff7   = {1'b0, balance} - 7'(LOSS_AMT);
    new_bal = balance;
    if (hit) new_bal = sum7[6] ? 6'd63 : sum7[5:0];
    else     new_bal = diff7[6] ? 6'd0 : diff7[5:0];
  end

  // Key is active-low: a falling edge of the synchronised level is a press.
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      key_s3 <= 1'b1;
      press  <= 1'b0;
    end else begin
      key_s1 <= start_key;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
      press  <= key_s3 & ~key_s2;
    end
  end

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT;
      balance    <= 6'(START_BAL);
      spin_num   <= 5'd0;
      busy       <= 1'b0;
      win_pulse  <= 1'b0;
      lose_pulse <= 1'b0;
      game_won   <= 1'b0;
      game_lost  <= 1'b0;
      lat_mode   <= 1'b0;
      lat_even   <= 1'b0;
      lat_num    <= 5'd0;
      spin_cnt   <= '0;
      hit        <= 1'b0;
    end else begin
      win_pulse  <= 1'b0;
      lose_pulse <= 1'b0;
      if (new_game) begin
        state     <= WAIT;
        balance   <= 6'(START_BAL);
        busy      <= 1'b0;
        game_won  <= 1'b0;
        game_lost <= 1'b0;
      end else begin
        case (state)
          WAIT: begin
            if (press) begin
              lat_mode <= mode_sel;
              lat_even <= guess_even;
              lat_num  <= guess_num;
              spin_cnt <= '0;
              busy     <= 1'b1;
              state    <= SPIN;
            end
          end
          SPIN: begin
            spin_cnt <= spin_cnt + 1'b1;
            if (spin_cnt == CW'(SPIN_CYCLES - 1)) begin
              spin_num <= randnum;
              state    <= JUDGE;
            end
          end
          JUDGE: begin
            hit   <= hit_now;
            busy  <= 1'b0;
            state <= UPDATE;
          end
          UPDATE: begin
            balance    <= new_bal;
            win_pulse  <= hit;
            lose_pulse <= ~hit;
            // Game-over decision looks at the balance this round produced.
            if (32'(new_bal) >= WIN_LIMIT) begin
              game_won <= 1'b1;
              state    <= WIN;
            end else if (new_bal == 6'd0) begin
              game_lost <= 1'b1;
              state     <= LOSE;
            end else begin
              state <= WAIT;
            end
          end
          WIN:     state <= WIN;
          LOSE:    state <= LOSE;
          default: state <= WAIT;
        endcase
      end
    end
  end

endmodule
